// File: rtl/led_status_ctl.sv
// Multi-channel LED status driver: off / on / shared blink / blink-code per channel.
// Optional LED_ACTIVE_LOW_EN inverts the led pins (0 = lit, reset drives all 1s).
module led_status_ctl #(
    parameter int unsigned NUM_LED     = 4,
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned TICK_HZ     = 10,
    parameter int unsigned BLINK_TICKS = 5,
    parameter int unsigned PULSE_TICKS = 2,
    parameter int unsigned PAUSE_TICKS = 10,
    parameter int unsigned CODE_W      = 3
) (
    input  logic                       clk_50m,
    input  logic                       rst,
    input  logic [2*NUM_LED-1:0]       mode,
    input  logic [CODE_W*NUM_LED-1:0]  code,
    output logic                       tick,
    output logic [NUM_LED-1:0]         led
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W    = $clog2(TICK_DIV);
    localparam int unsigned TMR_MAX0 = (BLINK_TICKS > PULSE_TICKS) ? BLINK_TICKS : PULSE_TICKS;
    localparam int unsigned TMR_MAX  = (TMR_MAX0 > PAUSE_TICKS) ? TMR_MAX0 : PAUSE_TICKS;
    localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [NUM_LED-1:0] LED_RST = '1;
    localparam logic               LED_POL = 1'b1;
`else
    localparam logic [NUM_LED-1:0] LED_RST = '0;
    localparam logic               LED_POL = 1'b0;
`endif

    typedef enum logic [1:0] {
        CODE_LOAD  = 2'd0,
        CODE_ON    = 2'd1,
        CODE_OFF   = 2'd2,
        CODE_PAUSE = 2'd3
    } code_state_e;

    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic              tick_q,  tick_d;
    logic [TMR_W-1:0]  bcnt_q,  bcnt_d;
    logic              phase_q, phase_d;
    code_state_e       st_q   [NUM_LED];
    code_state_e       st_d   [NUM_LED];
    logic [TMR_W-1:0]  tmr_q  [NUM_LED];
    logic [TMR_W-1:0]  tmr_d  [NUM_LED];
    logic [CODE_W-1:0] rem_q  [NUM_LED];
    logic [CODE_W-1:0] rem_d  [NUM_LED];
    logic [NUM_LED-1:0] lit_c;
    logic [NUM_LED-1:0] led_q, led_d;

    // Shared time base: prescaler strobe and the common blink phase.
    always_comb begin
        pre_d   = pre_q + PRE_W'(1);
        tick_d  = 1'b0;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (pre_q == PRE_W'(TICK_DIV - 1)) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
        if (tick_q) begin
            if (bcnt_q == TMR_W'(BLINK_TICKS - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + TMR_W'(1);
            end
        end
    end

    // Per-channel code sequencer; leaving code mode parks it in LOAD.
    always_comb begin
        for (int i = 0; i < NUM_LED; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
            rem_d[i] = rem_q[i];
            if (mode[2*i +: 2] != 2'b11) begin
                st_d[i]  = CODE_LOAD;
                tmr_d[i] = '0;
            end else if (tick_q) begin
                case (st_q[i])
                    CODE_LOAD: begin
                        rem_d[i] = code[CODE_W*i +: CODE_W];
                        tmr_d[i] = '0;
                        st_d[i]  = (code[CODE_W*i +: CODE_W] != '0) ? CODE_ON : CODE_PAUSE;
                    end
                    CODE_ON: begin
                        if (tmr_q[i] == TMR_W'(PULSE_TICKS - 1)) begin
                            tmr_d[i] = '0;
                            st_d[i]  = CODE_OFF;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TMR_W'(1);
                        end
                    end
                    CODE_OFF: begin
                        if (tmr_q[i] == TMR_W'(PULSE_TICKS - 1)) begin
                            tmr_d[i] = '0;
                            if (rem_q[i] > CODE_W'(1)) begin
                                rem_d[i] = rem_q[i] - CODE_W'(1);
                                st_d[i]  = CODE_ON;
                            end else begin
                                rem_d[i] = '0;
                                st_d[i]  = CODE_PAUSE;
                            end
                        end else begin
                            tmr_d[i] = tmr_q[i] + TMR_W'(1);
                        end
                    end
                    CODE_PAUSE: begin
                        if (tmr_q[i] == TMR_W'(PAUSE_TICKS - 1)) begin
                            tmr_d[i] = '0;
                            rem_d[i] = code[CODE_W*i +: CODE_W];
                            st_d[i]  = (code[CODE_W*i +: CODE_W] != '0) ? CODE_ON : CODE_PAUSE;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TMR_W'(1);
                        end
                    end
                    default: begin
                        st_d[i]  = CODE_LOAD;
                        tmr_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Output select per channel, then polarity.
    always_comb begin
        lit_c = '0;
        led_d = LED_RST;
        for (int i = 0; i < NUM_LED; i++) begin
            case (mode[2*i +: 2])
                2'b00:   lit_c[i] = 1'b0;
                2'b01:   lit_c[i] = 1'b1;
                2'b10:   lit_c[i] = phase_q;
                default: lit_c[i] = (st_q[i] == CODE_ON);
            endcase
            led_d[i] = lit_c[i] ^ LED_POL;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            led_q   <= LED_RST;
            for (int i = 0; i < NUM_LED; i++) begin
                st_q[i]  <= CODE_LOAD;
                tmr_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            for (int i = 0; i < NUM_LED; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

    assign tick = tick_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_status_ctl.sv
// Directed bench for led_status_ctl at TICK_DIV=10, BLINK=2, PULSE=1, PAUSE=3.
// Expected levels are expressed as "lit"; LED_ACTIVE_LOW_EN flips the pin polarity.
module tb_led_status_ctl;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [3:0] POL = 4'hF;
`else
    localparam logic [3:0] POL = 4'h0;
`endif

    logic        clk_50m;
    logic        rst;
    logic [7:0]  mode;
    logic [11:0] code;
    logic        tick;
    logic [3:0]  led;
    logic [3:0]  led_lit;

    int n_checks;
    int n_errors;
    int cyc;

    led_status_ctl #(
        .NUM_LED     (4),
        .CLK_FREQ_HZ (100),
        .TICK_HZ     (10),
        .BLINK_TICKS (2),
        .PULSE_TICKS (1),
        .PAUSE_TICKS (3),
        .CODE_W      (3)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .mode    (mode),
        .code    (code),
        .tick    (tick),
        .led     (led)
    );

    assign led_lit = led ^ POL;

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        #1;
        cyc++;
    endtask

    // Three reset edges, then release; cycle 1 is the first edge with rst low.
    task automatic apply_reset(input logic [7:0] m, input logic [11:0] c);
        rst  = 1'b1;
        mode = m;
        code = c;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    // Code=2: lit per tick interval 1,0,1,0,0,0,0; each interval is 10 cycles from base.
    function automatic logic code_exp(input int n, input int base);
        int idx;
        if (n < base) return 1'b0;
        idx = ((n - base) / 10) % 7;
        return (idx == 0) || (idx == 2);
    endfunction

    // Phase flips on edges 21, 41, ...; led follows one cycle later.
    function automatic logic blink_exp(input int n);
        if (n < 2) return 1'b0;
        return (((n - 2) / 20) % 2) == 1;
    endfunction

    initial begin
        logic e;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;

        // Reset state and prescaler cadence
        apply_reset(8'h00, 12'h000);
        check("rst_led", led, POL);
        check("rst_tick", tick, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            step();
            check("tick_cadence", tick, (n % 10) == 0);
        end

        // Static modes: one cycle latency, tick-independent
        mode = 8'h01;
        check("static_pre", led_lit[0], 1'b0);
        step();
        check("static_on", led_lit[0], 1'b1);
        check("static_off", led_lit[1], 1'b0);
        for (int n = 0; n < 15; n++) begin
            step();
            check("static_hold", led_lit[1:0], 2'b01);
        end

        // Blink: ch2 from reset, ch3 joins at cycle 51
        apply_reset(8'h20, 12'h000);
        for (int n = 1; n <= 100; n++) begin
            if (n == 51) mode = 8'hA0;
            step();
            check("blink_ch2", led_lit[2], blink_exp(n));
            check("blink_ch3", led_lit[3], (n >= 51) ? blink_exp(n) : 1'b0);
        end

        // Code mode, code=2
        apply_reset(8'h03, 12'h002);
        for (int n = 1; n <= 160; n++) begin
            step();
            check("code2", led_lit[0], code_exp(n, 12));
        end

        // Code mode, code=0 stays dark
        apply_reset(8'h03, 12'h000);
        for (int n = 1; n <= 60; n++) begin
            step();
            check("code0", led_lit[0], 1'b0);
        end

        // Mode blip to 01 during the second pulse restarts a full burst
        apply_reset(8'h03, 12'h002);
        for (int n = 1; n <= 130; n++) begin
            if (n == 34) mode = 8'h01;
            if (n == 35) mode = 8'h03;
            step();
            if (n < 34)       e = code_exp(n, 12);
            else if (n == 34) e = 1'b1;
            else              e = code_exp(n, 42);
            check("code_restart", led_lit[0], e);
        end

        // Reset pulse mid-sequence
        rst = 1'b1;
        step();
        check("midrst_led", led, POL);
        check("midrst_tick", tick, 1'b0);
        rst = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            check("midrst_tick_cad", tick, (n % 10) == 0);
            check("midrst_code", led_lit[0], code_exp(n, 12));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
